// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit field widths, flit-type codes and the packetizer FSM states.
package noc_pkg;

    localparam int FLIT_W  = 40;
    localparam int COORD_W = 4;
    localparam int SEQ_W   = 22;
    localparam int DATA_W  = 36;
    localparam int LEN_W   = 3;

    localparam logic [1:0] FT_HEAD = 2'b11;
    localparam logic [1:0] FT_BODY = 2'b10;
    localparam logic [1:0] FT_TAIL = 2'b01;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HEAD = 2'd1,
        ST_BODY = 2'd2,
        ST_TAIL = 2'd3
    } pkt_state_t;

endpackage

// File: rtl/pkt_fifo.sv
// Data word FIFO for the packetizer; a push is judged against the occupancy at the start of
// the cycle, so a push into a full FIFO is dropped even when a pop happens on the same edge.
module pkt_fifo
    import noc_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      push,
    input  logic [DATA_W-1:0]         wr_data,
    input  logic                      pop,
    output logic [DATA_W-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]    count,
    output logic                      full,
    output logic                      overflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              full_q, full_d;
    logic              ovf_q, ovf_d;
    logic              push_ok;
    logic              pop_ok;

    always_comb begin
        push_ok  = push && (count_q != CNT_W'(DEPTH));
        pop_ok   = pop && (count_q != '0);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        if (push_ok && !pop_ok)      count_d = count_q + CNT_W'(1);
        else if (pop_ok && !push_ok) count_d = count_q - CNT_W'(1);
        // Full and overflow are registered so they describe the FIFO after the edge.
        full_d = (count_d == CNT_W'(DEPTH));
        ovf_d  = push && !push_ok;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            ovf_q    <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= wr_data;
    end

    assign rd_data  = mem_q[rd_ptr_q];
    assign count    = count_q;
    assign full     = full_q;
    assign overflow = ovf_q;

endmodule

// File: rtl/pe_packetizer.sv
// PE-side packetizer: buffers data words and, per command, emits one header, the payload flits
// and a tail flit toward the router's local input port.
module pe_packetizer
    import noc_pkg::*;
#(
    parameter logic [COORD_W-1:0] SRC_X = 4'h0,
    parameter logic [COORD_W-1:0] SRC_Y = 4'h0,
    parameter int                 DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic [DATA_W-1:0]      wr_data,
    output logic                   fifo_full,
    output logic                   overflow,
    input  logic                   cmd_valid,
    input  logic [COORD_W-1:0]     cmd_dst_x,
    input  logic [COORD_W-1:0]     cmd_dst_y,
    input  logic [LEN_W-1:0]       cmd_len,
    output logic                   cmd_ready,
    output logic                   req_out,
    output logic [FLIT_W-1:0]      flit_out,
    input  logic                   grnt_in,
    output logic                   pkt_done,
    output pkt_state_t             dbg_state,
    output logic [$clog2(DEPTH):0] dbg_count
);

    // Handshakes: a command is taken on an edge where cmd_valid && cmd_ready; a flit moves on an
    // edge where req_out && grnt_in, and flit_out is held unchanged until that edge.
    localparam int CNT_W = $clog2(DEPTH) + 1;

    pkt_state_t         state_q, state_d;
    logic [COORD_W-1:0] dst_x_q, dst_x_d;
    logic [COORD_W-1:0] dst_y_q, dst_y_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   rem_q, rem_d;
    logic [SEQ_W-1:0]   seq_q, seq_d;
    logic [DATA_W-1:0]  fifo_rd_data;
    logic [CNT_W-1:0]   fifo_count;
    logic               xfer;
    logic               fifo_pop;

    pkt_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (wr_en),
        .wr_data  (wr_data),
        .pop      (fifo_pop),
        .rd_data  (fifo_rd_data),
        .count    (fifo_count),
        .full     (fifo_full),
        .overflow (overflow)
    );

    assign req_out  = (state_q != ST_IDLE);
    assign xfer     = req_out && grnt_in;
    assign fifo_pop = xfer && ((state_q == ST_BODY) || (state_q == ST_TAIL));
    // Only start a packet once every word it needs is already buffered.
    assign cmd_ready = (state_q == ST_IDLE) && cmd_valid
                       && (32'(fifo_count) >= 32'(cmd_len) + 32'd1);

    always_comb begin
        state_d  = state_q;
        dst_x_d  = dst_x_q;
        dst_y_d  = dst_y_q;
        len_d    = len_q;
        rem_d    = rem_q;
        seq_d    = seq_q;
        flit_out = '0;
        pkt_done = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cmd_ready) begin
                    dst_x_d = cmd_dst_x;
                    dst_y_d = cmd_dst_y;
                    len_d   = cmd_len;
                    state_d = ST_HEAD;
                end
            end
            ST_HEAD: begin
                flit_out = {FT_HEAD, SRC_X, SRC_Y, dst_x_q, dst_y_q, seq_q};
                if (grnt_in) begin
                    rem_d   = len_q;
                    state_d = (len_q == '0) ? ST_TAIL : ST_BODY;
                end
            end
            ST_BODY: begin
                flit_out = {FT_BODY, fifo_rd_data, 2'b00};
                if (grnt_in) begin
                    rem_d = rem_q - LEN_W'(1);
                    if (rem_q == LEN_W'(1)) state_d = ST_TAIL;
                end
            end
            ST_TAIL: begin
                flit_out = {FT_TAIL, fifo_rd_data, 2'b00};
                if (grnt_in) begin
                    pkt_done = 1'b1;
                    seq_d    = seq_q + SEQ_W'(1);
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            dst_x_q <= '0;
            dst_y_q <= '0;
            len_q   <= '0;
            rem_q   <= '0;
            seq_q   <= '0;
        end else begin
            state_q <= state_d;
            dst_x_q <= dst_x_d;
            dst_y_q <= dst_y_d;
            len_q   <= len_d;
            rem_q   <= rem_d;
            seq_q   <= seq_d;
        end
    end

    assign dbg_state = state_q;
    assign dbg_count = fifo_count;

endmodule

// File: doc/pe_packetizer.md
PE_PACKETIZER -- requirements
Module: pe_packetizer

Interface
REQ-001 Parameters: SRC_X default 4'h0, this node's X coordinate; SRC_Y default 4'h0, this node's Y coordinate; DEPTH default 8, data FIFO entries (power of 2).
REQ-002 clk  in  1  single clock; all state changes on the rising edge.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 wr_en  in  1  PE pushes one data word.
REQ-005 wr_data  in  36  data word.
REQ-006 fifo_full  out  1  FIFO holds DEPTH words.
REQ-007 overflow  out  1  one-cycle pulse when a push is dropped.
REQ-008 cmd_valid  in  1  PE requests transmission of one packet.
REQ-009 cmd_dst_x, cmd_dst_y  in  4 each  destination coordinates.
REQ-010 cmd_len  in  3  number of data words minus 1 (1..8 words).
REQ-011 cmd_ready  out  1  command accepted this cycle.
REQ-012 req_out  out  1  flit valid toward the router local (PE) input port.
REQ-013 flit_out  out  40  flit toward the router.
REQ-014 grnt_in  in  1  router accepts the flit.
REQ-015 pkt_done  out  1  one-cycle pulse when the tail flit is accepted.

Function
REQ-016 Header flit format: {2'b11, SRC_X, SRC_Y, dst_x, dst_y, seq[21:0]}.
REQ-017 Payload flit format: {2'b10, word[35:0], 2'b00}.
REQ-018 Tail flit format: {2'b01, word[35:0], 2'b00}.
REQ-019 A packet of N words SHALL consist of one header, N-1 payload flits and one tail flit carrying word N, in FIFO order.
REQ-020 The FSM SHALL have four states: IDLE, HEAD, BODY and TAIL.
REQ-021 cmd_ready SHALL equal (state==IDLE && cmd_valid && count >= cmd_len+1), which prevents FIFO underflow.
REQ-022 When cmd_ready is high, the block SHALL latch dst_x, dst_y and cmd_len, and SHALL enter HEAD on the next cycle.
REQ-023 req_out SHALL be high exactly in HEAD, BODY and TAIL.
REQ-024 flit_out SHALL hold stable while req_out is high and grnt_in is low; flit_out SHALL be 40'b0 in IDLE.
REQ-025 A flit transfers on an edge where req_out && grnt_in; grnt_in while req_out is low SHALL be ignored.
REQ-026 HEAD transitions on transfer: to TAIL if len==0, else to BODY with remaining=len.
REQ-027 BODY pops the FIFO head on each transfer and decrements remaining; it SHALL go to TAIL when remaining reaches 0.
REQ-028 TAIL pops on transfer, pulses pkt_done, increments seq (wrapping 2^22-1 to 0) and returns to IDLE.
REQ-029 With grnt_in held high, an N-word packet SHALL take N+1 consecutive cycles, and the next command SHALL be accepted no earlier than one cycle after return to IDLE.
REQ-030 Push behaviour: a push SHALL be accepted only if count<DEPTH at the start of the cycle; otherwise the word is dropped and overflow pulses. This applies even with a simultaneous pop.
REQ-031 A simultaneous accepted push and pop SHALL leave count unchanged; read and write pointers wrap modulo DEPTH.
REQ-032 fifo_full SHALL be registered so that it reflects the count after the edge.

Reset
REQ-033 On rst the block SHALL set state=IDLE, count=0, pointers=0, seq=0, req_out=0, flit_out=0, cmd_ready=0, pkt_done=0 and overflow=0, asynchronously.
REQ-034 Reset mid-packet SHALL truncate the packet: req_out drops immediately and buffered words are discarded.

Structure
REQ-035 The flit-type codes (HEAD=2'b11, BODY=2'b10, TAIL=2'b01), flit width 40, coordinate width 4 and seq width 22 SHALL reside in a shared noc_pkg.
REQ-036 The data FIFO SHALL be one sub-module, pkt_fifo (36-bit, DEPTH-parameterised, with push, pop, count, full and overflow).

Verification
REQ-037 Scenario: SRC=(1,2); push 3 words A,B,C; cmd dst=(3,10), len=2; grnt_in=1 -> flits 11_1_2_3_A_000000, 10_A_00, 10_B_00, 01_C_00 on 4 consecutive cycles; pkt_done on cycle 4.
REQ-038 Scenario: single word, len=0 -> header then tail only; seq in the next header = 1.
REQ-039 Scenario: grnt_in low for 3 cycles during BODY -> flit_out and req_out stable, no pop, and the sequence resumes intact.
REQ-040 Scenario: 9 pushes into an empty DEPTH=8 FIFO -> fifo_full after the 8th; the 9th raises overflow for one cycle and count stays 8.
REQ-041 Scenario: cmd len=3 with only 2 words buffered -> cmd_ready stays 0 until 2 more words are pushed.
REQ-042 Scenario: rst asserted during BODY -> req_out=0 within the same cycle, count=0, state IDLE; the following packet header carries seq=0.
